// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue and its FIFO.
// Holds the NOP filler word, the reset PC and the fetch FSM state encodings.
// Imported by inst_prefetch_queue and sync_fifo.
package inst_prefetch_queue_pkg;

  // Fetch FSM state type and encodings
  typedef logic [0:0] ipq_state_t;

  localparam ipq_state_t  IPQ_IDLE  = 1'b0;
  localparam ipq_state_t  IPQ_REQ   = 1'b1;

  // addi x0, x0, 0 -- presented downstream whenever the queue is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [7:0]  RESET_PC  = 8'h00;

endpackage

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// Purpose: generic synchronous FIFO with clear, push/pop and occupancy count.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
// Ports: clk, rst (sync active-low), clear (sync flush), push/push_data, pop,
//        head (entry at read pointer), full, empty, count.
module sync_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == FULL_LVL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Purpose: instruction fetch front end -- one outstanding imem req/ack, PC-tagged prefetch FIFO, redirect flush.
// Latency: fetched word at inst_out the cycle after imem_ack; redirect to first valid is 2 cycles best case.
// Backpressure: inst_ready low fills the queue; no request issues unless a slot is free for its data.
// Ports: clk, rst (sync active-low); imem_req/imem_addr/imem_ack/imem_rdata (memory side);
//        redirect_valid/redirect_addr (flush + new PC); inst_valid/inst_ready/inst_out/inst_pc (decode side);
//        q_count (occupancy). Optional macro IPQ_PERF_CNT_EN adds fetch_cnt and flush_cnt.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int N        = 32,
  parameter int MEM_ADDR = 8,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [MEM_ADDR-1:0]      imem_addr,
  input  logic                     imem_ack,
  input  logic [N-1:0]             imem_rdata,
  input  logic                     redirect_valid,
  input  logic [MEM_ADDR-1:0]      redirect_addr,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [N-1:0]             inst_out,
  output logic [MEM_ADDR-1:0]      inst_pc,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef IPQ_PERF_CNT_EN
  ,
  output logic [31:0]              fetch_cnt,
  output logic [31:0]              flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_LVL = DEPTH[CW-1:0];

  typedef struct packed {
    logic [N-1:0]        inst;
    logic [MEM_ADDR-1:0] pc;
  } entry_t;

  ipq_state_t          state;
  ipq_state_t          state_nxt;
  logic                squash;
  logic                squash_nxt;
  logic [MEM_ADDR-1:0] fetch_pc;
  logic [MEM_ADDR-1:0] fetch_pc_nxt;
  logic [MEM_ADDR-1:0] req_addr;
  logic [MEM_ADDR-1:0] redirect_pc;
  logic [CW-1:0]       count_nxt;
  logic                ack_in_req;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  entry_t              push_entry;
  entry_t              head_entry;

  // Word-aligned redirect target; masking keeps every input bit in use.
  assign redirect_pc = redirect_addr & ~MEM_ADDR'(3);

  assign ack_in_req = (state == IPQ_REQ) && imem_ack;
  // A redirect in the ack cycle discards the data; a squashed ack belongs to a stale request.
  assign push       = ack_in_req && !squash && !redirect_valid && (!fifo_full || pop);
  // The flush wins over a same-cycle pop.
  assign pop        = !fifo_empty && inst_ready && !redirect_valid;
  assign push_entry = '{inst: imem_rdata, pc: req_addr};

  always_comb begin
    count_nxt = q_count + CW'(push) - CW'(pop);
    if (redirect_valid) count_nxt = '0;
  end

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (redirect_valid)  fetch_pc_nxt = redirect_pc;
    else if (push)       fetch_pc_nxt = fetch_pc + MEM_ADDR'(4);
  end

  // Redirect while a request is still waiting: the eventual ack must be thrown away.
  always_comb begin
    squash_nxt = squash;
    if (ack_in_req)                                   squash_nxt = 1'b0;
    else if ((state == IPQ_REQ) && redirect_valid)    squash_nxt = 1'b1;
  end

  // Only decide a new request once the current one (if any) has completed.
  // Comparing post-update occupancy keeps a slot reserved for the in-flight word.
  always_comb begin
    state_nxt = state;
    if ((state == IPQ_IDLE) || ack_in_req)
      state_nxt = (count_nxt < DEPTH_LVL) ? IPQ_REQ : IPQ_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IPQ_IDLE;
      squash   <= 1'b0;
      fetch_pc <= MEM_ADDR'(RESET_PC);
      req_addr <= MEM_ADDR'(RESET_PC);
    end else begin
      state    <= state_nxt;
      squash   <= squash_nxt;
      fetch_pc <= fetch_pc_nxt;
      // The request address is frozen while a request is outstanding.
      if ((state == IPQ_IDLE) || ack_in_req)
        req_addr <= fetch_pc_nxt;
    end
  end

  assign imem_req  = (state == IPQ_REQ);
  assign imem_addr = req_addr;

  sync_fifo #(
    .WIDTH (N + MEM_ADDR),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (q_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst_out   = fifo_empty ? N'(NOP_INSTR) : head_entry.inst;
  assign inst_pc    = fifo_empty ? '0 : head_entry.pc;

`ifdef IPQ_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push && (fetch_cnt != '1))           fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_valid && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Purpose: self-checking bench for inst_prefetch_queue (table-driven cycle vectors plus streaming sequences).
// Latency: table rows are checked 1 time unit after the posedge that consumes them.
// Backpressure: inst_ready is driven directly from the stimulus.
module tb_inst_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [7:0]  inst_pc;
  logic [2:0]  q_count;
`ifdef IPQ_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Memory side: either the table drives ack/rdata, or an always-acking model does.
  logic        mem_en;
  logic        tbl_ack;
  logic [31:0] tbl_rdata;
  logic        auto_ack;
  logic [31:0] auto_rdata;

  assign imem_ack   = mem_en ? auto_ack   : tbl_ack;
  assign imem_rdata = mem_en ? auto_rdata : tbl_rdata;

  int n_checks;
  int n_fail;

  inst_prefetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .q_count        (q_count)
`ifdef IPQ_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [7:0] a);
    return {16'hC0DE, a, ~a};
  endfunction

  // Memory model: acknowledges every request in the cycle it is raised.
  initial begin
    auto_ack   = 1'b0;
    auto_rdata = '0;
    forever begin
      @(negedge clk);
      auto_ack   = mem_en && imem_req;
      auto_rdata = word(imem_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic hold_reset();
    step();
    rst            = 1'b0;
    mem_en         = 1'b0;
    tbl_ack        = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    step();
    step();
  endtask

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [7:0]  raddr;
    logic        ready;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [31:0] e_out;
    logic [7:0]  e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  logic [7:0] c_pcs [3];
  int         got;
  int         first_c;
  int         n_req;
  logic [7:0] last_addr;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b0;
    mem_en         = 1'b0;
    tbl_ack        = 1'b0;
    tbl_rdata      = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    inst_ready     = 1'b0;

    //            rst ack rdata         rd  raddr  rdy | req addr   vld out           pc     cnt
    vecs[0]  = '{1'b0,1'b0,32'h0,        1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0,NOP,         8'h00,3'd0}; // reset
    vecs[1]  = '{1'b1,1'b0,32'h0,        1'b0,8'h00,1'b0, 1'b1,8'h00,1'b0,NOP,         8'h00,3'd0}; // IDLE->REQ
    vecs[2]  = '{1'b1,1'b1,32'h11111111, 1'b0,8'h00,1'b0, 1'b1,8'h04,1'b1,32'h11111111,8'h00,3'd1}; // ack, b2b
    vecs[3]  = '{1'b1,1'b1,32'h22222222, 1'b0,8'h00,1'b1, 1'b1,8'h08,1'b1,32'h22222222,8'h04,3'd1}; // push+pop
    vecs[4]  = '{1'b1,1'b0,32'h0,        1'b0,8'h00,1'b0, 1'b1,8'h08,1'b1,32'h22222222,8'h04,3'd1}; // wait
    vecs[5]  = '{1'b1,1'b0,32'h0,        1'b1,8'h43,1'b1, 1'b1,8'h08,1'b0,NOP,         8'h00,3'd0}; // redirect mid-req
    vecs[6]  = '{1'b1,1'b1,32'h33333333, 1'b0,8'h00,1'b1, 1'b1,8'h40,1'b0,NOP,         8'h00,3'd0}; // squashed ack
    vecs[7]  = '{1'b1,1'b1,32'h44444444, 1'b0,8'h00,1'b0, 1'b1,8'h44,1'b1,32'h44444444,8'h40,3'd1};
    vecs[8]  = '{1'b1,1'b1,32'h55555555, 1'b1,8'h80,1'b1, 1'b1,8'h80,1'b0,NOP,         8'h00,3'd0}; // redirect+ack+pop
    vecs[9]  = '{1'b1,1'b0,32'h0,        1'b1,8'hA0,1'b0, 1'b1,8'h80,1'b0,NOP,         8'h00,3'd0};
    vecs[10] = '{1'b1,1'b0,32'h0,        1'b1,8'hC4,1'b0, 1'b1,8'h80,1'b0,NOP,         8'h00,3'd0}; // last wins
    vecs[11] = '{1'b1,1'b1,32'h66666666, 1'b0,8'h00,1'b0, 1'b1,8'hC4,1'b0,NOP,         8'h00,3'd0};
    vecs[12] = '{1'b1,1'b1,32'h77777777, 1'b0,8'h00,1'b0, 1'b1,8'hC8,1'b1,32'h77777777,8'hC4,3'd1};
    vecs[13] = '{1'b0,1'b0,32'h0,        1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0,NOP,         8'h00,3'd0}; // reset mid-REQ
    vecs[14] = '{1'b1,1'b1,32'h88888888, 1'b0,8'h00,1'b0, 1'b1,8'h00,1'b0,NOP,         8'h00,3'd0}; // late ack ignored
    vecs[15] = '{1'b0,1'b0,32'h0,        1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0,NOP,         8'h00,3'd0};

    for (int i = 0; i < NV; i++) begin
      step();
      rst            = vecs[i].rst;
      tbl_ack        = vecs[i].ack;
      tbl_rdata      = vecs[i].rdata;
      redirect_valid = vecs[i].redir;
      redirect_addr  = vecs[i].raddr;
      inst_ready     = vecs[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.imem_req", i),   imem_req,   vecs[i].e_req);
      chk($sformatf("v%0d.imem_addr", i),  imem_addr,  vecs[i].e_addr);
      chk($sformatf("v%0d.inst_valid", i), inst_valid, vecs[i].e_valid);
      chk($sformatf("v%0d.inst_out", i),   inst_out,   vecs[i].e_out);
      chk($sformatf("v%0d.inst_pc", i),    inst_pc,    vecs[i].e_pc);
      chk($sformatf("v%0d.q_count", i),    q_count,    vecs[i].e_cnt);
    end

    // Streaming from reset with single-cycle memory: PCs 0x00, 0x04, 0x08.
    hold_reset();
    rst        = 1'b1;
    mem_en     = 1'b1;
    inst_ready = 1'b1;
    got        = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      step();
      if (inst_valid) begin
        chk($sformatf("stream.pc%0d", got),  inst_pc,  8'(got * 4));
        chk($sformatf("stream.out%0d", got), inst_out, word(8'(got * 4)));
        got++;
      end
    end
    chk("stream.count", got, 3);

    // Fill to DEPTH with consumer stalled, then release exactly one entry.
    hold_reset();
    rst        = 1'b1;
    mem_en     = 1'b1;
    inst_ready = 1'b0;
    repeat (12) step();
    chk("full.q_count", q_count, 3'd4);
    chk("full.head_pc", inst_pc, 8'h00);
    chk("full.head_out", inst_out, word(8'h00));
    n_req = 0;
    for (int c = 0; c < 3; c++) begin
      if (imem_req) n_req++;
      step();
    end
    chk("full.req_while_full", n_req, 0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    n_req      = 0;
    last_addr  = '0;
    for (int c = 0; c < 8; c++) begin
      if (imem_req) begin
        n_req++;
        last_addr = imem_addr;
      end
      step();
    end
    chk("full.refill_reqs", n_req, 1);
    chk("full.refill_addr", last_addr, 8'h10);
    chk("full.q_count_after", q_count, 3'd4);
    chk("full.head_pc_after", inst_pc, 8'h04);

    // Redirect out of IDLE to 0xF8: best-case latency and PC wrap.
    hold_reset();
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 8'hF8;
    mem_en         = 1'b1;
    inst_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("wrap.valid_t1", inst_valid, 1'b0);
    chk("wrap.req_t1", imem_req, 1'b1);
    chk("wrap.addr_t1", imem_addr, 8'hF8);
    c_pcs[0] = 8'hF8;
    c_pcs[1] = 8'hFC;
    c_pcs[2] = 8'h00;
    got      = 0;
    first_c  = -1;
    for (int c = 0; c < 40 && got < 3; c++) begin
      step();
      if (inst_valid) begin
        if (first_c < 0) first_c = c;
        chk($sformatf("wrap.pc%0d", got),  inst_pc,  c_pcs[got]);
        chk($sformatf("wrap.out%0d", got), inst_out, word(c_pcs[got]));
        got++;
      end
    end
    chk("wrap.count", got, 3);
    chk("wrap.first_valid_cycle", first_c, 0);

`ifdef IPQ_PERF_CNT_EN
    // 4 + 4 + 2 accepted fetches, 2 redirects.
    hold_reset();
    rst = 1'b1;
    step();
    chk("perf.fetch_reset", fetch_cnt, 32'd0);
    chk("perf.flush_reset", flush_cnt, 32'd0);
    mem_en = 1'b1;
    repeat (10) step();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h20;
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
    inst_ready = 1'b1;
    step();
    step();
    inst_ready = 1'b0;
    repeat (5) step();
    mem_en = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h60;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    chk("perf.fetch_cnt", fetch_cnt, 32'd10);
    chk("perf.flush_cnt", flush_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
